// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
//   state_e      : controller state encoding (also visible on the debug port)
//   DEF_*        : default address map / SRAM geometry
//   HALF_W/WORD_W: SRAM and pipeline data widths
//   TIMER_W      : width of the per-phase wait counter (WAIT_CYCLES 0..7)
//   sat_inc      : saturating increment used by the optional statistics
package sram_mem_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] DEF_MEM_BASE = 32'd1024;
  localparam int unsigned DEF_SRAM_AW  = 18;
  localparam int unsigned HALF_W       = 16;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned TIMER_W      = 3;

  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sram_mem_controller_timer.sv
// sram_phase_timer: length counter for one halfword phase.
//   clk, rst      : clock, asynchronous active-low reset
//   loadIn        : high in the cycle before a phase starts; loads WAIT_CYCLES
//   lastOut       : current cycle is the final cycle of the phase
//   lastNextOut   : the following cycle will be the final cycle of its phase
module sram_phase_timer
  import sram_mem_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic loadIn,
  output logic lastOut,
  output logic lastNextOut
);

  localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(WAIT_CYCLES);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // Counts down to zero and parks there; zero marks the phase's last cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (loadIn) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign lastOut     = (cnt_q == '0);
  assign lastNextOut = (cnt_d == '0);

endmodule

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: runs MEM-stage 32-bit loads/stores as two halfword
// phases (LOW then HIGH) on a 16-bit asynchronous SRAM, stalling the pipeline
// with readyOut=0 while the access is in flight.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   MEM_R_ENIn, MEM_W_ENIn   : load / store request (store wins if both)
//   addrIn, wrDataIn         : byte address and store data
//   rdDataOut                : last loaded word
//   readyOut                 : 0 = freeze pipeline
//   sramAddrOut, sramDqOut, sramDqIn, sramDqOeOut, sramWeNOut : SRAM pins
//   dbgStateOut              : current controller state
// Optional build macro SRAM_MEM_CONTROLLER_STATS_EN adds statLoadsOut,
// statStoresOut and statStallCyclesOut saturating counters.
//
// Handshake: a request (MEM_R_ENIn|MEM_W_ENIn) seen in IDLE is captured at the
// next rising edge and readyOut drops in that same cycle; the pipeline holds
// its request until it observes readyOut=1, which happens for exactly one
// cycle (DONE). A request still present in the IDLE cycle after DONE is a new
// access.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] MEM_BASE    = DEF_MEM_BASE,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_ENIn,
  input  logic               MEM_W_ENIn,
  input  logic [WORD_W-1:0]  addrIn,
  input  logic [WORD_W-1:0]  wrDataIn,
  output logic [WORD_W-1:0]  rdDataOut,
  output logic               readyOut,
  output logic [SRAM_AW-1:0] sramAddrOut,
  output logic [HALF_W-1:0]  sramDqOut,
  input  logic [HALF_W-1:0]  sramDqIn,
  output logic               sramDqOeOut,
  output logic               sramWeNOut,
  output state_e             dbgStateOut
`ifdef SRAM_MEM_CONTROLLER_STATS_EN
  ,
  output logic [WORD_W-1:0]  statLoadsOut,
  output logic [WORD_W-1:0]  statStoresOut,
  output logic [WORD_W-1:0]  statStallCyclesOut
`endif
);

  state_e state_q, state_d;

  logic               req;
  logic [SRAM_AW-2:0] hw_in;
  logic               capture, phase_load, phase_last, phase_last_next;

  logic [SRAM_AW-2:0] hw_q, hw_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               wr_q, wr_d;
  logic [WORD_W-1:0]  rd_q, rd_d;
  logic [SRAM_AW-1:0] saddr_q, saddr_d;
  logic [HALF_W-1:0]  dq_q, dq_d;
  logic               oe_q, oe_d;
  logic               wen_q, wen_d;

  assign req   = MEM_R_ENIn | MEM_W_ENIn;
  // Word slot within the SRAM: (addr - base) / 4, wrapping modulo the array.
  assign hw_in = (SRAM_AW-1)'((addrIn - MEM_BASE) >> 2);

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .loadIn      (phase_load),
    .lastOut     (phase_last),
    .lastNextOut (phase_last_next)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req)        state_d = ST_LOW;
      ST_LOW:  if (phase_last) state_d = ST_HIGH;
      ST_HIGH: if (phase_last) state_d = ST_DONE;
      ST_DONE:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    readyOut   = 1'b0;
    capture    = 1'b0;
    phase_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        readyOut   = !req;
        capture    = req;
        phase_load = req;
      end
      ST_LOW:  phase_load = phase_last;
      ST_DONE: readyOut   = 1'b1;
      default: ;
    endcase
  end

  // Request capture; a store wins when both enables are high.
  always_comb begin
    hw_d   = hw_q;
    data_d = data_q;
    wr_d   = wr_q;
    if (capture) begin
      hw_d   = hw_in;
      data_d = wrDataIn;
      wr_d   = MEM_W_ENIn;
    end
  end

  // Pin values are registered from the upcoming state so each phase starts
  // with stable address/data. WE_N stays low for all but the last phase
  // cycle (hold time), except with zero wait states where it pulses once.
  always_comb begin
    saddr_d = saddr_q;
    dq_d    = dq_q;
    oe_d    = 1'b0;
    wen_d   = 1'b1;
    if (state_d == ST_LOW) begin
      saddr_d = {hw_d, 1'b0};
      if (wr_d) dq_d = data_d[HALF_W-1:0];
    end else if (state_d == ST_HIGH) begin
      saddr_d = {hw_d, 1'b1};
      if (wr_d) dq_d = data_d[WORD_W-1:HALF_W];
    end
    if (state_d != ST_IDLE) oe_d = wr_d;
    if ((state_d == ST_LOW || state_d == ST_HIGH) && wr_d &&
        (WAIT_CYCLES == 0 || !phase_last_next)) begin
      wen_d = 1'b0;
    end
  end

  // Load data is sampled on the last cycle of each read phase.
  always_comb begin
    rd_d = rd_q;
    if (phase_last && !wr_q) begin
      if (state_q == ST_LOW)       rd_d[HALF_W-1:0]      = sramDqIn;
      else if (state_q == ST_HIGH) rd_d[WORD_W-1:HALF_W] = sramDqIn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hw_q    <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      saddr_q <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      wen_q   <= 1'b1;
    end else begin
      hw_q    <= hw_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      saddr_q <= saddr_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      wen_q   <= wen_d;
    end
  end

  assign rdDataOut   = rd_q;
  assign sramAddrOut = saddr_q;
  assign sramDqOut   = dq_q;
  assign sramDqOeOut = oe_q;
  assign sramWeNOut  = wen_q;
  assign dbgStateOut = state_q;

`ifdef SRAM_MEM_CONTROLLER_STATS_EN
  logic [WORD_W-1:0] loads_q, loads_d, stores_q, stores_d, stall_q, stall_d;

  always_comb begin
    loads_d  = loads_q;
    stores_d = stores_q;
    stall_d  = stall_q;
    if (state_q == ST_DONE) begin
      if (wr_q) stores_d = sat_inc(stores_q);
      else      loads_d  = sat_inc(loads_q);
    end
    if (!readyOut) stall_d = sat_inc(stall_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      stall_q  <= '0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
      stall_q  <= stall_d;
    end
  end

  assign statLoadsOut       = loads_q;
  assign statStoresOut      = stores_q;
  assign statStallCyclesOut = stall_q;
`endif

endmodule
